// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start pulse in IDLE latches the operands. busy is high for WIDTH cycles,
// then done pulses for one cycle with diff/borrow freshly updated.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only in IDLE
//   a, b   - minuend / subtrahend (WIDTH bits), sampled with start
//   bin    - borrow-in, sampled with start
//   busy   - operation in progress
//   done   - one-cycle completion pulse
//   diff   - result modulo 2^WIDTH, held between operations
//   borrow - borrow-out, 1 iff a < b + bin
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell applied to the current LSBs.
  always_comb begin
    d        = sh_a[0] ^ sh_b[0] ^ br;
    br_next  = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
    res_next = {d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // Publish on the last bit so no partial result is ever visible.
          if (cnt == LAST) begin
            diff   <= res_next;
            borrow <= br_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4): directed scenarios,
// an exhaustive operand sweep and random operations, all compared against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_diff;
  logic         exp_borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  task automatic model(input int ma, input int mb, input int mbin);
    exp_diff   = W'((ma - mb - mbin) & ((1 << W) - 1));
    exp_borrow = (ma < (mb + mbin));
  endtask

  // Called at a negedge in IDLE; returns at a negedge with the DUT back in IDLE.
  // intf >= 0 pulses a conflicting start during that busy cycle.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbin, input int intf);
    logic [W-1:0] held_diff;
    logic         held_borrow;
    held_diff   = exp_diff;
    held_borrow = exp_borrow;
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("diff_hold", 32'(diff), 32'(held_diff));
      chk("borrow_hold", 32'(borrow), 32'(held_borrow));
      if (i == intf) begin
        start = 1'b1; a = '0; b = '1; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    model(int'(va), int'(vb), int'(vbin));
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("diff", 32'(diff), 32'(exp_diff));
    chk("borrow", 32'(borrow), 32'(exp_borrow));
    @(negedge clk);
    chk("done_end", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int gap;
    int per;
    bit seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    exp_diff = '0; exp_borrow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic operation and borrow boundaries.
    run_op(4'b0101, 4'b0011, 1'b0, -1);
    chk("t1_diff", 32'(diff), 32'b0010);
    run_op(4'b0000, 4'b0001, 1'b0, -1);
    chk("t2a_diff", 32'(diff), 32'b1111);
    chk("t2a_borrow", 32'(borrow), 32'd1);
    run_op(4'b1111, 4'b1111, 1'b1, -1);
    chk("t2b_diff", 32'(diff), 32'b1111);
    chk("t2b_borrow", 32'(borrow), 32'd1);

    // start while busy is ignored.
    run_op(4'b1010, 4'b0101, 1'b0, 1);
    chk("t3_diff", 32'(diff), 32'b0101);
    chk("t3_borrow", 32'(borrow), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_no_extra_done", 32'(done), 32'd0);
      chk("t3_no_extra_busy", 32'(busy), 32'd0);
    end

    // Reset in the middle of an operation.
    a = 4'b0111; b = 4'b0010; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_diff", 32'(diff), 32'd0);
    chk("t4_rst_borrow", 32'(borrow), 32'd0);
    exp_diff = '0; exp_borrow = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      chk("t4_no_done", 32'(done), 32'd0);
      chk("t4_no_busy", 32'(busy), 32'd0);
    end
    run_op(4'b1000, 4'b0001, 1'b1, -1);
    chk("t4_diff", 32'(diff), 32'b0110);
    chk("t4_borrow", 32'(borrow), 32'd0);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    a = 4'b0001; b = 4'b0010; bin = 1'b0; start = 1'b1;
    model(1, 2, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("t5_first_done", 32'(seen), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("t5_diff", 32'(diff), 32'b1111);
      chk("t5_borrow", 32'(borrow), 32'd1);
      per = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        per++;
        if (done) seen = 1'b1;
        else chk("t5_diff_stable", 32'(diff), 32'(exp_diff));
        chk("t5_not_both", 32'(busy & done), 32'd0);
      end
      chk("t5_period", 32'(per), 32'(W + 2));
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Exhaustive sweep of (a, b, bin) with random idle gaps.
    for (int x = 0; x < 512; x++) begin
      run_op(W'(x >> 5), W'(x >> 1), x[0], -1);
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end

    // Random operations, some with interfering start pulses.
    for (int n = 0; n < 60; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor: the sequential, inverse-direction companion to the team's combinational ripple-carry adder (a, b, cin -> sum, carry). It computes diff = a - b - bin one bit per clock, LSB first, using a start/busy/done handshake. It sits beside the adder in the arithmetic library, for area-constrained datapaths that accept WIDTH-cycle latency.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
start  input  1  request. Sampled only in IDLE.
a  input  WIDTH  minuend. Sampled with start.
b  input  WIDTH  subtrahend. Sampled with start.
bin  input  1  borrow-in. Sampled with start.
busy  output  1  high while an operation is in progress (RUN state).
done  output  1  one-cycle pulse; diff/borrow have just been updated.
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
borrow  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - state = IDLE; busy = 0; done = 0; diff = 0; borrow = 0.
  - Internal shift registers, bit counter and running borrow cleared.
  - In-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start = 1 at an edge (E0): latch a, b into shift registers; running borrow = bin; counter = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy = 1), on each edge:
  - Bit operands a0, b0 = LSBs of the shift registers; br = running borrow.
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the MSB of a result shift register; shift operand registers right; counter++.
  - On the edge where counter == WIDTH-1 (edge E_WIDTH): copy the completed result into diff, copy br_next into borrow, go to DONE.
- DONE (busy = 0, done = 1): lasts exactly one cycle; next edge returns to IDLE.
- Latency and throughput:
  - done is high in the cycle following the WIDTH-th edge after E0.
  - busy is high for exactly WIDTH cycles.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start in RUN or DONE is ignored; a, b and bin changes there have no effect.
- diff and borrow change only on the edge entering DONE, or on reset. They hold their value between operations; no partial results are visible.
- start held high continuously: a new operation is accepted on the first edge in IDLE after each DONE.
- done and busy are never high together.
- Control outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=4; a=0101, b=0011, bin=0, one-cycle start -> busy high 4 cycles, then done pulse for 1 cycle; diff=0010, borrow=0.
2. a=0000, b=0001, bin=0 -> diff=1111, borrow=1. a=1111, b=1111, bin=1 -> diff=1111, borrow=1.
3. a=1010, b=0101, bin=0; during busy, pulse start with a=0000, b=1111 -> second request ignored; diff=0101, borrow=0; exactly one done pulse.
4. Start a=0111, b=0010; drop rst_n after 2 RUN cycles -> busy=0, diff=0000, borrow=0 immediately; no done. After release, a=1000, b=0001, bin=1 -> diff=0110, borrow=0.
5. start held high, a=0001, b=0010, bin=0 -> repeated ops, done period = 6 cycles; diff=1111, borrow=1. diff stable between done pulses.
6. Exhaustive sweep of all 512 (a, b, bin) combinations vs reference model (a-b-bin) mod 16 and borrow = (a < b+bin); check done/busy timing every operation.
